lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 70 +++++++
 rtl/lsu.sv | 133 +++++++++++++
 tb/tb_lsu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit: funct3 encodings, FSM states,
// access sizes and the default data/address widths.
package lsu_pkg;

    localparam int LSU_XLEN     = 32;
    localparam int LSU_ADDR_LEN = 14;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // funct3[2] only selects sign handling; the low bits pick the size, with 11 read as a word.
    function automatic size_e f3_size(input logic [2:0] f3);
        if ({1'b0, f3[1:0]} == F3_B) begin
            return SZ_B;
        end else if ({1'b0, f3[1:0]} == F3_H) begin
            return SZ_H;
        end else begin
            return SZ_W;
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: byte enables, store-data replication, load extraction and
// sign/zero extension, plus detection of misaligned halfword/word accesses.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wr_data,
    output logic [XLEN-1:0]   rdata_ext,
    output logic              misalign
);
    localparam int NB = XLEN / 8;

    size_e           size;
    logic [1:0]      lane;
    logic [XLEN-1:0] shifted;
    logic            sext;

    assign size = f3_size(funct3);
    assign sext = ~funct3[2];

    // Halfwords snap to an even lane and words to lane 0, so a misaligned access still
    // hits a legal lane group when it is not trapped.
    always_comb begin
        lane     = off;
        misalign = 1'b0;
        be       = {NB{1'b1}};
        case (size)
            SZ_B: begin
                lane = off;
                be   = {{(NB-1){1'b0}}, 1'b1} << off;
            end
            SZ_H: begin
                lane     = {off[1], 1'b0};
                misalign = off[0];
                be       = {{(NB-2){1'b0}}, 2'b11} << lane;
            end
            default: begin
                lane     = 2'b00;
                misalign = (off != 2'b00);
                be       = {NB{1'b1}};
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign wr_data[8*gi +: 8] = (size == SZ_B) ? wdata[7:0] :
                                        (size == SZ_H) ? wdata[8*(gi%2) +: 8] :
                                                         wdata[8*gi +: 8];
        end
    endgenerate

    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        case (size)
            SZ_B:    rdata_ext = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_ext = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time, runs a single bus request and returns
// a one-cycle response. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W ops instead of aligning them.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN     = LSU_XLEN,
    parameter int ADDR_LEN = LSU_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_is_store,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_misalign,
    output logic [ADDR_LEN-1:0] addr,
    output logic                rd_req,
    output logic                wr_req,
    input  logic                rd_ready,
    input  logic                wr_ready,
    output logic [XLEN/8-1:0]   be,
    output logic [XLEN-1:0]     wr_data,
    input  logic [XLEN-1:0]     rd_data
);
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_state_e state_reg;
    logic [2:0] funct3_reg;
    logic [1:0] off_reg;

    logic [2:0]        al_funct3;
    logic [1:0]        al_off;
    logic [XLEN/8-1:0] al_be;
    logic [XLEN-1:0]   al_wr_data;
    logic [XLEN-1:0]   al_rdata_ext;
    logic              al_misalign;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_LEN];
    assign req_ready      = (state_reg == S_IDLE);

    // One lane unit serves both phases: the incoming request while idle, the latched op
    // while waiting for read data.
    assign al_funct3 = (state_reg == S_IDLE) ? req_funct3    : funct3_reg;
    assign al_off    = (state_reg == S_IDLE) ? req_addr[1:0] : off_reg;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3    (al_funct3),
        .off       (al_off),
        .wdata     (req_wdata),
        .rdata     (rd_data),
        .be        (al_be),
        .wr_data   (al_wr_data),
        .rdata_ext (al_rdata_ext),
        .misalign  (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            funct3_reg    <= '0;
            off_reg       <= '0;
            rd_req        <= 1'b0;
            wr_req        <= 1'b0;
            be            <= '0;
            wr_data       <= '0;
            addr          <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_reg <= req_funct3;
                        off_reg    <= req_addr[1:0];
                        addr       <= {req_addr[ADDR_LEN-1:2], 2'b00};
                        if (TRAP_EN && al_misalign) begin
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                            resp_rdata    <= '0;
                            state_reg     <= S_RESP;
                        end else if (req_is_store) begin
                            wr_req    <= 1'b1;
                            be        <= al_be;
                            wr_data   <= al_wr_data;
                            state_reg <= S_WR_WAIT;
                        end else begin
                            rd_req    <= 1'b1;
                            be        <= al_be;
                            state_reg <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (rd_ready) begin
                        rd_req     <= 1'b0;
                        be         <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= al_rdata_ext;
                        state_reg  <= S_RESP;
                    end
                end
                S_WR_WAIT: begin
                    if (wr_ready) begin
                        wr_req     <= 1'b0;
                        be         <= '0;
                        wr_data    <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        state_reg  <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid    <= 1'b0;
                    resp_misalign <= 1'b0;
                    resp_rdata    <= '0;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected responses, a monitor pops and checks
// each resp_valid pulse; the bus side is driven by the stimulus task with a chosen delay.
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic [13:0] addr;
    logic        rd_req;
    logic        wr_req;
    logic        rd_ready;
    logic        wr_ready;
    logic [3:0]  be;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    lsu #(.XLEN(32), .ADDR_LEN(14)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_store  (req_is_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .addr          (addr),
        .rd_req        (rd_req),
        .wr_req        (wr_req),
        .rd_ready      (rd_ready),
        .wr_ready      (wr_ready),
        .be            (be),
        .wr_data       (wr_data),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        mis;
        int          due;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                chk({e.name, "_misalign"}, {31'd0, resp_misalign}, {31'd0, e.mis});
                chk({e.name, "_resp_cycle"}, cyc, e.due);
                chk({e.name, "_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
                $display("resp %-10s rdata=0x%08h mis=%0b cyc=%0d", e.name, resp_rdata, resp_misalign, cyc);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, sb.size(), 32'd0);
    endtask

    // One op: issue, serve the bus after k wait cycles, expect the response via the scoreboard.
    task automatic op(input string name, input bit st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                      input int k, input logic [13:0] eaddr, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic [31:0] erd, input bit trap);
        exp_t e;
        wait_ready(name);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        e.name  = name;
        e.rdata = erd;
        e.mis   = trap;
        e.due   = trap ? cyc + 1 : cyc + 2 + k;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555;
        if (trap) begin
            chk({name, "_no_rd_req"}, {31'd0, rd_req}, 32'd0);
            chk({name, "_no_wr_req"}, {31'd0, wr_req}, 32'd0);
        end else begin
            for (int j = 0; j <= k; j++) begin
                chk($sformatf("%s_req_hi_%0d", name, j), {31'd0, st ? wr_req : rd_req}, 32'd1);
                chk($sformatf("%s_addr_%0d", name, j), {18'd0, addr}, {18'd0, eaddr});
                chk($sformatf("%s_be_%0d", name, j), {28'd0, be}, {28'd0, ebe});
                if (st) chk($sformatf("%s_wr_data_%0d", name, j), wr_data, ewd);
                if (j == k) begin
                    if (st) wr_ready = 1'b1;
                    else begin
                        rd_ready = 1'b1;
                        rd_data  = rdv;
                    end
                end
                @(negedge clk);
                rd_ready = 1'b0;
                wr_ready = 1'b0;
                rd_data  = 32'hA5A5_A5A5;
            end
            chk({name, "_req_lo"}, {30'd0, rd_req, wr_req}, 32'd0);
            chk({name, "_be_idle"}, {28'd0, be}, 32'd0);
        end
        wait_drain(name);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        rd_ready     = 1'b0;
        wr_ready     = 1'b0;
        rd_data      = 32'hA5A5_A5A5;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
        chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_misalign", {31'd0, resp_misalign}, 32'd0);
        chk("rst_addr", {18'd0, addr}, 32'd0);
        chk("rst_be", {28'd0, be}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);

        //  name     st  f3      addr          wdata         rd_data       k  eaddr    be       wr_data       rdata         trap
        op("sw",     1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0,        1, 14'h2004, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0);
        op("lb",     0, 3'b000, 32'h0000_2003, 32'h0,         32'h8011_2233, 0, 14'h2000, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
        op("lbu",    0, 3'b100, 32'h0000_2003, 32'h0,         32'h8011_2233, 2, 14'h2000, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
        op("sh",     1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        0, 14'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
        op("lh",     0, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_FFFF, 1, 14'h2000, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0);
        op("lw_slow",0, 3'b010, 32'h0000_2010, 32'h0,         32'h1234_5678, 5, 14'h2010, 4'b1111, 32'h0,        32'h1234_5678, 1'b0);
        op("sb",     1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 32'h0,        0, 14'h2000, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0);
        op("lhu",    0, 3'b101, 32'h0000_2000, 32'h0,         32'h1234_F00D, 0, 14'h2000, 4'b0011, 32'h0,        32'h0000_F00D, 1'b0);
        op("lw_f3_11",0,3'b011, 32'h0000_2004, 32'h0,         32'h0BAD_C0DE, 0, 14'h2004, 4'b1111, 32'h0,        32'h0BAD_C0DE, 1'b0);
        op("sb_f3_1xx",1,3'b100,32'h0000_2002, 32'h0000_0077, 32'h0,        0, 14'h2000, 4'b0100, 32'h7777_7777, 32'h0,        1'b0);
        op("lw_mis", 0, 3'b010, 32'h0000_2001, 32'h0,         32'hCAFE_F00D, 0, 14'h2000, 4'b1111, 32'h0,
           TRAP ? 32'h0 : 32'hCAFE_F00D, TRAP);
        op("sh_mis", 1, 3'b001, 32'h0000_2003, 32'h0000_1234, 32'h0,        1, 14'h2000, 4'b1100, 32'h1234_1234, 32'h0,        TRAP);

        // Reset in the middle of a read: request drops, no response, then a normal load.
        wait_ready("rst_mid");
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h0000_2008;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_rd_req_hi", {31'd0, rd_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rd_req", {31'd0, rd_req}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mid_addr", {18'd0, addr}, 32'd0);
        $display("xact rst_mid aborted at cyc=%0d", cyc);
        repeat (3) @(negedge clk);
        op("lw_after_rst", 0, 3'b010, 32'h0000_200C, 32'h0, 32'h0102_0304, 1, 14'h200C, 4'b1111, 32'h0, 32'h0102_0304, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
